sim_result_checker: RTL and testbench

- Parametrised, cycle-accurate run monitor and result checker for the pipelined CPU system; replaces fixed-delay end-of-simulation checks with a synthesizable FSM.
- Snoops the data-memory write port and the PC.
- Detects program halt (PC stable) or timeout.
- Then verifies that a window of data-memory words is ascending and that a probed register holds an expected value; reports pass/fail with a diagnostic code.

---
 rtl/sim_result_checker.sv | 173 +++++++++++++++++
 tb/tb_sim_result_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_result_checker.sv
// sim_result_checker: run monitor and end-of-run result checker.
// Snoops dmem writes and PC, then checks word ordering and a register probe.
module sim_result_checker #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned NUM_WORDS     = 6,
  parameter int unsigned BASE_IDX      = 20,
  parameter int unsigned ADDR_SHIFT    = 0,
  parameter bit          SIGNED_CMP    = 1'b0,
  parameter int unsigned EXPECT_REG    = 12833,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 800,
  localparam int unsigned IW = $clog2(NUM_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             mem_write_i,
  input  logic [WIDTH-1:0] mem_addr_i,
  input  logic [WIDTH-1:0] mem_wdata_i,
  input  logic [WIDTH-1:0] reg_value_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [2:0]       fail_code_o,
  output logic [IW-1:0]    fail_index_o,
  output logic [31:0]      cycle_count_o
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [WIDTH-1:0] WBASE = WIDTH'(BASE_IDX);
  localparam logic [WIDTH-1:0] WLIM  = WIDTH'(BASE_IDX + NUM_WORDS);
  localparam logic [WIDTH-1:0] WEXP  = WIDTH'(EXPECT_REG);
  localparam logic [SW-1:0]    STB   = SW'(STABLE_CYCLES);
  localparam logic [31:0]      TMO   = 32'(TIMEOUT);
  localparam logic [IW-1:0]    KLAST = IW'(NUM_WORDS - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_CHECK, S_REG, S_PASS, S_FAIL
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q [NUM_WORDS];
  logic [NUM_WORDS-1:0] valid_q;
  logic [31:0]      cnt_q;
  logic [SW-1:0]    stable_q;
  logic [WIDTH-1:0] prev_pc_q;
  logic [IW-1:0]    k_q;
  logic             done_q, pass_q, fail_q;
  logic [2:0]       code_q;
  logic [IW-1:0]    idx_q;

  logic [WIDTH-1:0] widx;
  logic             win;
  logic [IW-1:0]    woff;
  logic [SW-1:0]    stable_d;
  logic [31:0]      cnt_d;
  logic [IW-1:0]    k1;
  logic             gt;

  // Write-window decode, stable/cycle next values, pair compare
  always_comb begin
    widx     = mem_addr_i >> ADDR_SHIFT;
    win      = mem_write_i && (widx >= WBASE) && (widx < WLIM);
    woff     = IW'(widx - WBASE);
    cnt_d    = cnt_q + 32'd1;
    stable_d = '0;
    if (pc_i == prev_pc_q)
      stable_d = (stable_q == STB) ? STB : stable_q + SW'(1);
    k1 = k_q + IW'(1);
    if (SIGNED_CMP)
      gt = $signed(shadow_q[k_q]) > $signed(shadow_q[k1]);
    else
      gt = shadow_q[k_q] > shadow_q[k1];
  end

  // Monitor FSM with registered verdict outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      prev_pc_q <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      code_q    <= '0;
      idx_q     <= '0;
      for (int i = 0; i < NUM_WORDS; i++)
        shadow_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start_i) begin
            state_q   <= S_RUN;
            valid_q   <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            prev_pc_q <= pc_i;
            k_q       <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            code_q    <= '0;
            idx_q     <= '0;
          end
        end
        S_RUN: begin
          cnt_q     <= cnt_d;
          stable_q  <= stable_d;
          prev_pc_q <= pc_i;
          if (win) begin
            shadow_q[woff] <= mem_wdata_i;
            valid_q[woff]  <= 1'b1;
          end
          if (stable_d == STB) begin
            state_q <= S_CHECK;
            k_q     <= '0;
          end else if (cnt_d == TMO) begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            code_q  <= 3'd3;
            idx_q   <= '0;
          end
        end
        S_CHECK: begin
          if (!valid_q[k_q] || !valid_q[k1]) begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            code_q  <= 3'd4;
            idx_q   <= k_q;
          end else if (gt) begin
            state_q <= S_FAIL;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            code_q  <= 3'd1;
            idx_q   <= k_q;
          end else if (k_q == KLAST) begin
            state_q <= S_REG;
          end else begin
            k_q <= k1;
          end
        end
        S_REG: begin
          done_q <= 1'b1;
          if (reg_value_i == WEXP) begin
            state_q <= S_PASS;
            pass_q  <= 1'b1;
          end else begin
            state_q <= S_FAIL;
            fail_q  <= 1'b1;
            code_q  <= 3'd2;
            idx_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign fail_code_o   = code_q;
  assign fail_index_o  = idx_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_sim_result_checker.sv
// tb_sim_result_checker: three checker variants driven in parallel
// against a transaction-level model plus literal spot checks.
module tb_sim_result_checker;

  localparam int NW   = 6;
  localparam int BASE = 20;
  localparam int STB  = 16;
  localparam int TMO  = 800;
  localparam logic [31:0] EXPR = 32'd12833;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mw = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rv = '0;

  logic [2:0]  done_w, pass_w, fail_w;
  logic [2:0]  code_w [3];
  logic [2:0]  idx_w [3];
  logic [31:0] cnt_w [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_result_checker dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pc_i(pc),
    .mem_write_i(mw), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .reg_value_i(rv), .done_o(done_w[0]), .pass_o(pass_w[0]),
    .fail_o(fail_w[0]), .fail_code_o(code_w[0]),
    .fail_index_o(idx_w[0]), .cycle_count_o(cnt_w[0]));

  sim_result_checker #(.SIGNED_CMP(1'b1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pc_i(pc),
    .mem_write_i(mw), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .reg_value_i(rv), .done_o(done_w[1]), .pass_o(pass_w[1]),
    .fail_o(fail_w[1]), .fail_code_o(code_w[1]),
    .fail_index_o(idx_w[1]), .cycle_count_o(cnt_w[1]));

  sim_result_checker #(.ADDR_SHIFT(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pc_i(pc),
    .mem_write_i(mw), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .reg_value_i(rv), .done_o(done_w[2]), .pass_o(pass_w[2]),
    .fail_o(fail_w[2]), .fail_code_o(code_w[2]),
    .fail_index_o(idx_w[2]), .cycle_count_o(cnt_w[2]));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int          sh [3] = '{0, 0, 2};
  bit          sg [3] = '{1'b0, 1'b1, 1'b0};
  int          ph [3];
  int          n [3];
  int          stab [3];
  int          remain [3];
  int          pcode [3];
  int          pidx [3];
  logic [31:0] ppc [3];
  logic [31:0] mem [3][NW];
  bit          wr [3][NW];
  bit          e_done [3], e_pass [3], e_fail [3];
  int          e_code [3], e_idx [3], e_cnt [3];
  logic [31:0] wi;

  function automatic bit gtr(input logic [31:0] a, input logic [31:0] b,
                             input bit s);
    return s ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  task automatic fin(input int d, input int c, input int i);
    e_done[d] = 1'b1;
    e_pass[d] = (c == 0);
    e_fail[d] = (c != 0);
    e_code[d] = c;
    e_idx[d]  = i;
    ph[d]     = 3;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        ph[d] = 0; n[d] = 0; stab[d] = 0; ppc[d] = '0;
        e_done[d] = 0; e_pass[d] = 0; e_fail[d] = 0;
        e_code[d] = 0; e_idx[d] = 0; e_cnt[d] = 0;
        for (int k = 0; k < NW; k++) begin
          mem[d][k] = '0; wr[d][k] = 0;
        end
      end else if (ph[d] == 0 || ph[d] == 3) begin
        if (start) begin
          ph[d] = 1; n[d] = 0; stab[d] = 0; ppc[d] = pc;
          for (int k = 0; k < NW; k++) wr[d][k] = 0;
          e_done[d] = 0; e_pass[d] = 0; e_fail[d] = 0;
          e_code[d] = 0; e_idx[d] = 0; e_cnt[d] = 0;
        end
      end else if (ph[d] == 1) begin
        n[d]++;
        e_cnt[d] = n[d];
        wi = addr >> sh[d];
        if (mw && wi >= BASE && wi < BASE + NW) begin
          mem[d][int'(wi) - BASE] = wdata;
          wr[d][int'(wi) - BASE]  = 1;
        end
        stab[d] = (pc == ppc[d]) ? stab[d] + 1 : 0;
        ppc[d] = pc;
        if (stab[d] >= STB) begin
          pcode[d] = 0; pidx[d] = 0; remain[d] = NW;
          for (int k = 0; k < NW - 1; k++) begin
            if (pcode[d] == 0) begin
              if (!wr[d][k] || !wr[d][k+1]) begin
                pcode[d] = 4; pidx[d] = k; remain[d] = k + 1;
              end else if (gtr(mem[d][k], mem[d][k+1], sg[d])) begin
                pcode[d] = 1; pidx[d] = k; remain[d] = k + 1;
              end
            end
          end
          ph[d] = 2;
        end else if (n[d] == TMO) begin
          fin(d, 3, 0);
        end
      end else begin
        remain[d]--;
        if (remain[d] == 0) begin
          if (pcode[d] != 0) fin(d, pcode[d], pidx[d]);
          else fin(d, (rv == EXPR) ? 0 : 2, 0);
        end
      end
    end
  end

  // Per-cycle comparison of every variant against the model
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("cyc_dut%0d", d),
            {done_w[d], pass_w[d], fail_w[d], code_w[d],
             (e_code[d] == 2) ? 3'(e_idx[d]) : idx_w[d], cnt_w[d]},
            {e_done[d], e_pass[d], e_fail[d], 3'(e_code[d]),
             3'(e_idx[d]), 32'(e_cnt[d])});
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wv [NW];
  bit          wm [NW];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [31:0] p);
    pc = p;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (!(&done_w) && b < 1000) begin
      step();
      b++;
    end
    chk("wait_done", {61'd0, done_w}, 64'd7);
    step();
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] v);
    mw = 1'b1; addr = a; wdata = v;
    step();
    mw = 1'b0;
  endtask

  task automatic prog(input logic [31:0] r);
    rv = r;
    do_start(32'h100);
    for (int k = 0; k < NW; k++)
      if (wm[k]) wr1(32'(BASE + k), wv[k]);
    wait_done();
  endtask

  task automatic set_words(input logic [31:0] a0, input logic [31:0] a3,
                           input bit m4);
    wv[0] = a0; wv[1] = 32'd5; wv[2] = 32'd5;
    wv[3] = a3; wv[4] = 32'd12; wv[5] = 32'd40;
    for (int k = 0; k < NW; k++) wm[k] = 1;
    wm[4] = m4;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_outs", {done_w, pass_w, fail_w, code_w[0], idx_w[0], cnt_w[0]},
        64'd0);
    rst_n = 1'b1;
    step();

    // reset in the middle of a run
    do_start(32'd0);
    for (int j = 1; j <= 50; j++) begin
      pc = 32'(j);
      step();
    end
    chk("cnt50", 64'(cnt_w[0]), 64'd50);
    #2 rst_n = 1'b0;
    #1 chk("midrst", {done_w[0], pass_w[0], fail_w[0], code_w[0],
                      idx_w[0], cnt_w[0]}, 64'd0);
    step();
    #2 rst_n = 1'b1;
    step();

    // ascending words, correct register
    set_words(32'd3, 32'd9, 1);
    prog(EXPR);
    chk("pass0", {pass_w[0], fail_w[0], code_w[0]}, {1'b1, 1'b0, 3'd0});
    chk("pass_cnt", 64'(cnt_w[0]), 64'd16);
    chk("pass1", 64'(pass_w[1]), 64'd1);

    // order violation at pair 2
    set_words(32'd3, 32'd2, 1);
    prog(EXPR);
    chk("ord_code", {fail_w[0], code_w[0], idx_w[0]}, {1'b1, 3'd1, 3'd2});

    // -1 first: unsigned fails, signed passes
    set_words(32'hFFFF_FFFF, 32'd9, 1);
    prog(EXPR);
    chk("uns_neg", {code_w[0], idx_w[0]}, {3'd1, 3'd0});
    chk("sgn_neg", {pass_w[1], code_w[1]}, {1'b1, 3'd0});

    // register mismatch
    set_words(32'd3, 32'd9, 1);
    prog(32'd12832);
    chk("reg_code", 64'(code_w[0]), 64'd2);

    // word 24 never written
    set_words(32'd3, 32'd9, 0);
    prog(EXPR);
    chk("unwr", {code_w[0], idx_w[0]}, {3'd4, 3'd3});

    // byte-addressed variant
    rv = EXPR;
    do_start(32'h100);
    wr1(32'h51, 32'd0);
    wr1(32'h4C, 32'd99);
    wr1(32'h54, 32'd7);
    wr1(32'h54, 32'd1);
    wr1(32'h58, 32'd2);
    wr1(32'h5C, 32'd3);
    wr1(32'h60, 32'd4);
    wr1(32'h64, 32'd5);
    wait_done();
    chk("shift_pass", {pass_w[2], code_w[2]}, {1'b1, 3'd0});
    chk("shift_w0", {code_w[0], idx_w[0]}, {3'd4, 3'd0});

    // restart after PASS, then timeout
    do_start(32'd0);
    chk("restart", {done_w[2], pass_w[2], cnt_w[2]}, 64'd0);
    for (int j = 1; j <= TMO; j++) begin
      pc = 32'(j);
      step();
    end
    chk("tmo", {fail_w[0], code_w[0], idx_w[0], cnt_w[0]},
        {1'b1, 3'd3, 3'd0, 32'd800});
    step();
    chk("tmo_frz", 64'(cnt_w[0]), 64'd800);

    // halt on the same cycle as the timeout
    do_start(32'd0);
    for (int j = 1; j <= TMO; j++) begin
      pc = (j <= 784) ? 32'(j) : 32'd784;
      step();
    end
    chk("tie_run", {done_w[0], cnt_w[0]}, {1'b0, 32'd800});
    wait_done();
    chk("tie_chk", {code_w[0], idx_w[0], cnt_w[0]},
        {3'd4, 3'd0, 32'd800});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
